// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (A, high priority) and a long-latency unit (B).
// Optional starvation guard for B is compiled in with `define RF_ARB_STARVE_GUARD_EN.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_waddr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic              starve_evt
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} gnt_state_t;

  gnt_state_t        state_q, state_d;
  logic              force_b;
  logic              zero_q;
  logic              wr_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign force_b = (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      starve_evt <= 1'b0;
    end else begin
      starve_evt <= b_ready && force_b;
      if (!b_valid || b_ready)
        starve_cnt <= '0;
      else if (!force_b)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign force_b    = 1'b0;
  assign starve_evt = 1'b0;
`endif

  always_comb begin
    b_ready = 1'b0;
    a_ready = 1'b0;
    state_d = IDLE;
    if (rst_n) begin
      b_ready = b_valid && (!a_valid || force_b);
      a_ready = a_valid && !b_ready;
    end
    if (a_ready)
      state_d = GNT_A;
    else if (b_ready)
      state_d = GNT_B;
  end

  assign sel_addr = (state_d == GNT_B) ? b_waddr : a_waddr;
  assign sel_data = (state_d == GNT_B) ? b_wdata : a_wdata;
  // Writes to $0 are accepted but never reach the register file or the counter.
  assign wr_en    = (state_d != IDLE) && (sel_addr != '0);
  assign we       = (state_q != IDLE) && !zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      zero_q   <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      wr_count <= '0;
    end else begin
      state_q <= state_d;
      zero_q  <= (sel_addr == '0);
      if (wr_en) begin
        waddr    <= sel_addr;
        wdata    <= sel_data;
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: every accepted transfer predicts the next-cycle write port.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_waddr = '0, b_waddr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [15:0] wr_count;
  logic        starve_evt;

  rf_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .we(we), .waddr(waddr), .wdata(wdata), .wr_count(wr_count), .starve_evt(starve_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;
  logic        rst_prev = 1'b0;
  logic        evt_pend = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: outputs at this negedge reflect the previous posedge; inputs seen now go to the next one.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_prev) begin
      sb_q.delete();
      exp_cnt = '0;
      check_eq("rst_we", 64'(we), 64'(0));
      check_eq("rst_cnt", 64'(wr_count), 64'(0));
      check_eq("rst_evt", 64'(starve_evt), 64'(0));
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("we", 64'(we), 64'(e.w));
        if (e.w) begin
          check_eq("waddr", 64'(waddr), 64'(e.a));
          check_eq("wdata", 64'(wdata), 64'(e.d));
          exp_cnt = exp_cnt + 16'd1;
        end
      end else begin
        check_eq("we_idle", 64'(we), 64'(0));
      end
      check_eq("wr_count", 64'(wr_count), 64'(exp_cnt));
      check_eq("starve_evt", 64'(starve_evt), 64'(evt_pend));
    end
    evt_pend = 1'b0;
    if (rst_n) begin
      check_eq("rdy_a_rule", 64'(a_ready), 64'(a_valid && !b_ready));
      check_eq("rdy_b_excl", 64'(b_ready && !b_valid), 64'(0));
      if (!a_valid)
        check_eq("rdy_b_free", 64'(b_ready), 64'(b_valid));
      if (a_valid && a_ready)
        sb_q.push_back('{w: (a_waddr != 0), a: a_waddr, d: a_wdata});
      else if (b_valid && b_ready)
        sb_q.push_back('{w: (b_waddr != 0), a: b_waddr, d: b_wdata});
      else
        sb_q.push_back('{w: 1'b0, a: 5'd0, d: 32'd0});
`ifdef RF_ARB_STARVE_GUARD_EN
      // With A still requesting, B can only be granted by the guard.
      evt_pend = b_valid && b_ready && a_valid;
`endif
    end else begin
      check_eq("rst_a_ready", 64'(a_ready), 64'(0));
      check_eq("rst_b_ready", 64'(b_ready), 64'(0));
    end
    rst_prev = rst_n;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b_ready(output bit found, output int waited, input int limit);
    found = 1'b0;
    waited = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (b_ready) found = 1'b1;
      else waited++;
    end
  endtask

  initial begin
    bit found;
    int waited;

    // Reset with both requesters active
    a_valid = 1'b1; a_waddr = 5'd9; a_wdata = 32'h9;
    b_valid = 1'b1; b_waddr = 5'd10; b_wdata = 32'hA;
    repeat (10) step();
    a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
    repeat (2) step();

    // A only
    a_valid = 1'b1; a_waddr = 5'd1; a_wdata = 32'hDEADBEEF;
    step();
    a_valid = 1'b0;
    step();

    // Contention: A wins, B follows
    a_valid = 1'b1; a_waddr = 5'd2; a_wdata = 32'h22;
    b_valid = 1'b1; b_waddr = 5'd3; b_wdata = 32'h33;
    step();
    a_valid = 1'b0;
    wait_b_ready(found, waited, 4);
    check_eq("contend_b_found", 64'(found), 64'(1));
    check_eq("contend_b_wait", 64'(waited), 64'(0));
    step();
    b_valid = 1'b0;
    step();

    // Back-to-back A writes
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_waddr = 5'(11 + i); a_wdata = 32'h1000 + 32'(i);
      step();
    end
    a_valid = 1'b0;
    step();

    // Starvation guard
    a_valid = 1'b1; a_waddr = 5'd6; a_wdata = 32'h6;
    b_valid = 1'b1; b_waddr = 5'd5; b_wdata = 32'h5;
    wait_b_ready(found, waited, 12);
`ifdef RF_ARB_STARVE_GUARD_EN
    check_eq("guard_found", 64'(found), 64'(1));
    check_eq("guard_wait", 64'(waited), 64'(4));
    step();
    b_valid = 1'b0;
    step();
    a_valid = 1'b0;
`else
    check_eq("noguard_starved", 64'(found), 64'(0));
    step();
    a_valid = 1'b0;
    wait_b_ready(found, waited, 4);
    check_eq("noguard_b_after", 64'(found), 64'(1));
    step();
    b_valid = 1'b0;
`endif
    repeat (2) step();

    // Register $0 write is swallowed
    a_valid = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    check_eq("zero_a_ready", 64'(a_ready), 64'(1));
    step();
    a_valid = 1'b0;
    repeat (2) step();

    // Reset on the edge after an accepted transfer
    a_valid = 1'b1; a_waddr = 5'd7; a_wdata = 32'h77;
    step();
    a_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midop_cnt", 64'(wr_count), 64'(0));
    check_eq("midop_we", 64'(we), 64'(0));
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
